fcs_frame_counter: RTL and testbench

Parametrised frame-length counter for the FCS datapath. It latches a frame length in bits at frame start, then tracks consumption of STEP-bit beats from the parallel CRC engine. It flags the final, possibly partial, beat with its valid-bit count and pulses done after the last beat. It replaces the single-bit fixed counter and adds multi-bit steps, stall support, abort, size checking and back-to-back frames.

---
 rtl/fcs_pkg.sv | 19 +
 rtl/fcs_frame_counter.sv | 83 ++++++++
 tb/tb_fcs_frame_counter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fcs_pkg.sv
// Shared types and elaboration helpers for the FCS frame counter.
package fcs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } fcs_state_t;

    // Width that holds 0..max_bits inclusive.
    function automatic int cnt_w(input int max_bits);
        return $clog2(max_bits) + 1;
    endfunction

    function automatic bit step_legal(input int step);
        return (step >= 1) && (step <= 64) && ((step & (step - 1)) == 0);
    endfunction

endpackage

// File: rtl/fcs_frame_counter.sv
// Frame-length counter: latches a bit length on Start, consumes STEP-bit beats, flags the final partial beat.
// Latency: Busy one cycle after Start, Cnt_done one cycle after the last beat; stalls by holding Cnt_En low.
module fcs_frame_counter
    import fcs_pkg::*;
#(
    parameter int MAX_BITS = 1024,
    parameter int STEP     = 8,
    parameter int CNT_W    = cnt_w(MAX_BITS),
    parameter int VB_W     = $clog2(STEP) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [CNT_W-1:0] Data_Size,
    input  logic             Cnt_En,
    input  logic             Abort,
    output logic             Busy,
    output logic             Last_Beat,
    output logic [VB_W-1:0]  Valid_Bits,
    output logic [CNT_W-1:0] Bit_Count,
    output logic             Cnt_done,
    output logic             Size_Err
);

    generate
        if (!step_legal(STEP)) begin : g_bad_step
            $error("fcs_frame_counter: STEP must be a power of two in 1..64");
        end
    endgenerate

    fcs_state_t       state;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] beat;
    logic             size_ok;

    // beat = min(rem, STEP); compared at 32 bits so STEP need not fit in CNT_W
    assign beat      = (32'(rem) < STEP) ? rem : CNT_W'(STEP);
    assign Busy      = (state == ST_COUNT);
    assign Last_Beat = Busy && (32'(rem) <= STEP);
    assign Valid_Bits = Busy ? VB_W'(beat) : '0;
    assign size_ok   = (Data_Size != '0) && (Data_Size <= CNT_W'(MAX_BITS));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            rem       <= '0;
            Bit_Count <= '0;
            Cnt_done  <= 1'b0;
            Size_Err  <= 1'b0;
        end else begin
            Cnt_done <= 1'b0;
            Size_Err <= 1'b0;
            case (state)
                ST_COUNT: begin
                    if (Abort) begin
                        state <= ST_IDLE;
                    end else if (Cnt_En) begin
                        rem       <= rem - beat;
                        Bit_Count <= Bit_Count + beat;
                        if (Last_Beat) begin
                            state    <= ST_DONE;
                            Cnt_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE behave alike; Abort suppresses a coincident Start
                    state <= ST_IDLE;
                    if (!Abort && Start) begin
                        if (size_ok) begin
                            rem       <= Data_Size;
                            Bit_Count <= '0;
                            state     <= ST_COUNT;
                        end else begin
                            Size_Err <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fcs_frame_counter.sv
// Directed self-checking bench for fcs_frame_counter (MAX_BITS=1024, STEP=8).
module tb_fcs_frame_counter;

    localparam int CNT_W = 11;
    localparam int VB_W  = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             Start;
    logic [CNT_W-1:0] Data_Size;
    logic             Cnt_En;
    logic             Abort;
    logic             Busy;
    logic             Last_Beat;
    logic [VB_W-1:0]  Valid_Bits;
    logic [CNT_W-1:0] Bit_Count;
    logic             Cnt_done;
    logic             Size_Err;

    int n_checks = 0;
    int n_pass   = 0;

    fcs_frame_counter #(.MAX_BITS(1024), .STEP(8)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Data_Size(Data_Size),
        .Cnt_En(Cnt_En), .Abort(Abort), .Busy(Busy), .Last_Beat(Last_Beat),
        .Valid_Bits(Valid_Bits), .Bit_Count(Bit_Count), .Cnt_done(Cnt_done),
        .Size_Err(Size_Err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pulses Start for one cycle; on return we are in cycle 1 of the frame.
    task automatic pulse_start(input logic [CNT_W-1:0] ds);
        Start = 1'b1;
        Data_Size = ds;
        tick();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; Start = 1'b0; Data_Size = '0; Cnt_En = 1'b0; Abort = 1'b0;
        tick(); tick();
        n_checks++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else n_pass++;
        n_checks++; if (Last_Beat !== 1'b0) $display("FAIL reset_last: got %b want 0", Last_Beat); else n_pass++;
        n_checks++; if (Valid_Bits !== 4'd0) $display("FAIL reset_vb: got %0d want 0", Valid_Bits); else n_pass++;
        n_checks++; if (Bit_Count !== 11'd0) $display("FAIL reset_count: got %0d want 0", Bit_Count); else n_pass++;
        n_checks++; if (Cnt_done !== 1'b0) $display("FAIL reset_done: got %b want 0", Cnt_done); else n_pass++;
        n_checks++; if (Size_Err !== 1'b0) $display("FAIL reset_err: got %b want 0", Size_Err); else n_pass++;
        RST = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        Cnt_En = 1'b1;
        pulse_start(11'd64);
        for (int i = 1; i <= 8; i++) begin
            n_checks++; if (Busy !== 1'b1) $display("FAIL full_busy c%0d: got %b want 1", i, Busy); else n_pass++;
            n_checks++; if (Valid_Bits !== 4'd8) $display("FAIL full_vb c%0d: got %0d want 8", i, Valid_Bits); else n_pass++;
            n_checks++; if (Last_Beat !== (i == 8)) $display("FAIL full_last c%0d: got %b want %b", i, Last_Beat, (i == 8)); else n_pass++;
            n_checks++; if (Cnt_done !== 1'b0) $display("FAIL full_early_done c%0d: got %b want 0", i, Cnt_done); else n_pass++;
            tick();
        end
        n_checks++; if (Cnt_done !== 1'b1) $display("FAIL full_done: got %b want 1", Cnt_done); else n_pass++;
        n_checks++; if (Busy !== 1'b0) $display("FAIL full_busy_done: got %b want 0", Busy); else n_pass++;
        n_checks++; if (Bit_Count !== 11'd64) $display("FAIL full_count: got %0d want 64", Bit_Count); else n_pass++;
        n_checks++; if (Valid_Bits !== 4'd0) $display("FAIL full_vb_idle: got %0d want 0", Valid_Bits); else n_pass++;
        Cnt_En = 1'b0;
        tick();
        n_checks++; if (Cnt_done !== 1'b0) $display("FAIL full_done_pulse: got %b want 0", Cnt_done); else n_pass++;
    endtask

    task automatic test_partial_beat();
        Cnt_En = 1'b1;
        pulse_start(11'd13);
        n_checks++; if (Valid_Bits !== 4'd8) $display("FAIL part_vb1: got %0d want 8", Valid_Bits); else n_pass++;
        n_checks++; if (Last_Beat !== 1'b0) $display("FAIL part_last1: got %b want 0", Last_Beat); else n_pass++;
        tick();
        n_checks++; if (Valid_Bits !== 4'd5) $display("FAIL part_vb2: got %0d want 5", Valid_Bits); else n_pass++;
        n_checks++; if (Last_Beat !== 1'b1) $display("FAIL part_last2: got %b want 1", Last_Beat); else n_pass++;
        n_checks++; if (Bit_Count !== 11'd8) $display("FAIL part_mid_count: got %0d want 8", Bit_Count); else n_pass++;
        tick();
        n_checks++; if (Cnt_done !== 1'b1) $display("FAIL part_done: got %b want 1", Cnt_done); else n_pass++;
        n_checks++; if (Bit_Count !== 11'd13) $display("FAIL part_count: got %0d want 13", Bit_Count); else n_pass++;
        Cnt_En = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        Cnt_En = 1'b1;
        pulse_start(11'd32);
        for (int c = 1; c <= 7; c++) begin
            Cnt_En = (c % 2) == 1;
            n_checks++; if (Cnt_done !== 1'b0) $display("FAIL stall_early_done c%0d: got %b want 0", c, Cnt_done); else n_pass++;
            if (c == 6) begin
                n_checks++; if (Bit_Count !== 11'd24) $display("FAIL stall_mid_count: got %0d want 24", Bit_Count); else n_pass++;
                n_checks++; if (Last_Beat !== 1'b1) $display("FAIL stall_last_held: got %b want 1", Last_Beat); else n_pass++;
            end
            tick();
        end
        Cnt_En = 1'b0;
        n_checks++; if (Cnt_done !== 1'b1) $display("FAIL stall_done: got %b want 1", Cnt_done); else n_pass++;
        n_checks++; if (Bit_Count !== 11'd32) $display("FAIL stall_count: got %0d want 32", Bit_Count); else n_pass++;
        tick();
    endtask

    task automatic test_abort();
        Cnt_En = 1'b1;
        pulse_start(11'd64);
        tick(); tick(); tick();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        Cnt_En = 1'b0;
        n_checks++; if (Busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", Busy); else n_pass++;
        n_checks++; if (Cnt_done !== 1'b0) $display("FAIL abort_done: got %b want 0", Cnt_done); else n_pass++;
        n_checks++; if (Bit_Count !== 11'd24) $display("FAIL abort_count: got %0d want 24", Bit_Count); else n_pass++;
        tick();
        n_checks++; if (Cnt_done !== 1'b0) $display("FAIL abort_done_late: got %b want 0", Cnt_done); else n_pass++;
    endtask

    task automatic test_size_err();
        pulse_start(11'd0);
        n_checks++; if (Size_Err !== 1'b1) $display("FAIL err_zero: got %b want 1", Size_Err); else n_pass++;
        n_checks++; if (Busy !== 1'b0) $display("FAIL err_zero_busy: got %b want 0", Busy); else n_pass++;
        n_checks++; if (Bit_Count !== 11'd24) $display("FAIL err_count_kept: got %0d want 24", Bit_Count); else n_pass++;
        tick();
        n_checks++; if (Size_Err !== 1'b0) $display("FAIL err_pulse: got %b want 0", Size_Err); else n_pass++;
        pulse_start(11'd1025);
        n_checks++; if (Size_Err !== 1'b1) $display("FAIL err_1025: got %b want 1", Size_Err); else n_pass++;
        n_checks++; if (Busy !== 1'b0) $display("FAIL err_1025_busy: got %b want 0", Busy); else n_pass++;
        tick();
        // Abort wins over Start, legal or not
        Abort = 1'b1;
        pulse_start(11'd0);
        n_checks++; if (Size_Err !== 1'b0) $display("FAIL abort_err: got %b want 0", Size_Err); else n_pass++;
        pulse_start(11'd16);
        Abort = 1'b0;
        n_checks++; if (Busy !== 1'b0) $display("FAIL abort_start: got %b want 0", Busy); else n_pass++;
        // Upper boundary is legal
        pulse_start(11'd1024);
        n_checks++; if (Busy !== 1'b1) $display("FAIL max_busy: got %b want 1", Busy); else n_pass++;
        n_checks++; if (Size_Err !== 1'b0) $display("FAIL max_err: got %b want 0", Size_Err); else n_pass++;
        n_checks++; if (Bit_Count !== 11'd0) $display("FAIL max_count_clr: got %0d want 0", Bit_Count); else n_pass++;
        // Start while counting is ignored
        pulse_start(11'd16);
        n_checks++; if (Busy !== 1'b1) $display("FAIL ignore_start_busy: got %b want 1", Busy); else n_pass++;
        n_checks++; if (Valid_Bits !== 4'd8) $display("FAIL ignore_start_vb: got %0d want 8", Valid_Bits); else n_pass++;
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        Cnt_En = 1'b1;
        pulse_start(11'd16);
        tick();
        n_checks++; if (Last_Beat !== 1'b1) $display("FAIL b2b_last: got %b want 1", Last_Beat); else n_pass++;
        tick();
        n_checks++; if (Cnt_done !== 1'b1) $display("FAIL b2b_done1: got %b want 1", Cnt_done); else n_pass++;
        n_checks++; if (Bit_Count !== 11'd16) $display("FAIL b2b_count1: got %0d want 16", Bit_Count); else n_pass++;
        pulse_start(11'd16);
        n_checks++; if (Busy !== 1'b1) $display("FAIL b2b_busy2: got %b want 1", Busy); else n_pass++;
        n_checks++; if (Bit_Count !== 11'd0) $display("FAIL b2b_count_clr: got %0d want 0", Bit_Count); else n_pass++;
        n_checks++; if (Cnt_done !== 1'b0) $display("FAIL b2b_done_clr: got %b want 0", Cnt_done); else n_pass++;
        tick(); tick();
        n_checks++; if (Cnt_done !== 1'b1) $display("FAIL b2b_done2: got %b want 1", Cnt_done); else n_pass++;
        n_checks++; if (Bit_Count !== 11'd16) $display("FAIL b2b_count2: got %0d want 16", Bit_Count); else n_pass++;
        Cnt_En = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        Cnt_En = 1'b1;
        pulse_start(11'd40);
        tick(); tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        Cnt_En = 1'b0;
        n_checks++; if (Busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", Busy); else n_pass++;
        n_checks++; if (Bit_Count !== 11'd0) $display("FAIL rst_mid_count: got %0d want 0", Bit_Count); else n_pass++;
        n_checks++; if (Valid_Bits !== 4'd0) $display("FAIL rst_mid_vb: got %0d want 0", Valid_Bits); else n_pass++;
        n_checks++; if (Last_Beat !== 1'b0) $display("FAIL rst_mid_last: got %b want 0", Last_Beat); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (Cnt_done !== 1'b0) $display("FAIL rst_mid_done c%0d: got %b want 0", i, Cnt_done); else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_partial_beat();
        test_stall();
        test_abort();
        test_size_err();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
